cp0_exc: RTL and testbench

Coprocessor-0 exception/interrupt unit for the multi-cycle MIPS-lite core. It is the return-side partner of the next-PC logic. It raises the interrupt request that makes the controller vector the PC to 0x0000_4180, and it captures the interrupted PC into EPC at that moment. It then holds EPC so the controller can route it back to the PC on `eret`. It also serves `mfc0`/`mtc0` accesses to SR, Cause, EPC and PRId.

---
 rtl/cp0_exc.sv | 102 ++++++++++
 tb/tb_cp0_exc.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc.sv
// Coprocessor-0 exception/interrupt unit: SR, Cause, EPC and PRId with interrupt request generation.
// Optional CP0_HWINT_SYNC_EN adds a two-flop synchronizer on each HWInt line ahead of Cause.IP.
module cp0_exc #(
    parameter logic [31:0] PRID = 32'h4D49_5053
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic [31:0] DIn,
    input  logic [4:0]  Sel,
    input  logic        Wen,
    input  logic        EXLSet,
    input  logic        EXLClr,
    input  logic [5:0]  HWInt,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);
    localparam int unsigned IRQ_W = 6;
    localparam logic [4:0] SEL_SR    = 5'd12;
    localparam logic [4:0] SEL_CAUSE = 5'd13;
    localparam logic [4:0] SEL_EPC   = 5'd14;
    localparam logic [4:0] SEL_PRID  = 5'd15;

    logic [IRQ_W-1:0] im;
    logic [IRQ_W-1:0] ip;
    logic             exl;
    logic             ie;
    logic [31:0]      epc_q;
    logic [IRQ_W-1:0] hw_in;

    logic unused_pc_low;
    assign unused_pc_low = ^PC[1:0];

`ifdef CP0_HWINT_SYNC_EN
    logic [IRQ_W-1:0] sync1;
    logic [IRQ_W-1:0] sync2;

    // Two-flop synchronizer for asynchronous device lines
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= HWInt;
            sync2 <= sync1;
        end
    end
    assign hw_in = sync2;
`else
    assign hw_in = HWInt;
`endif

    wire sr_write  = Wen && (Sel == SEL_SR);
    wire epc_write = Wen && (Sel == SEL_EPC);

    // Status/cause state; EXLSet beats EXLClr beats an SR write for the EXL bit only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im  <= '0;
            ie  <= 1'b0;
            exl <= 1'b0;
            ip  <= '0;
        end else begin
            ip <= hw_in;
            if (sr_write) begin
                im <= DIn[15:10];
                ie <= DIn[0];
            end
            if (EXLSet)
                exl <= 1'b1;
            else if (EXLClr)
                exl <= 1'b0;
            else if (sr_write)
                exl <= DIn[1];
        end
    end

    // PC capture on interrupt acceptance overrides a same-cycle mtc0 to EPC
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            epc_q <= '0;
        else if (EXLSet)
            epc_q <= {PC[31:2], 2'b00};
        else if (epc_write)
            epc_q <= {DIn[31:2], 2'b00};
    end

    assign EPC    = epc_q;
    assign IntReq = (|(ip & im)) & ie & ~exl;

    always_comb begin
        DOut = '0;
        case (Sel)
            SEL_SR:    DOut = {16'h0000, im, 8'h00, exl, ie};
            SEL_CAUSE: DOut = {16'h0000, ip, 10'h000};
            SEL_EPC:   DOut = epc_q;
            SEL_PRID:  DOut = PRID;
            default:   DOut = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_exc.sv
// Self-checking bench for cp0_exc: directed test-plan steps followed by randomized traffic
// compared against an architectural model of the CP0 registers.
module tb_cp0_exc;
    localparam logic [31:0] PRID = 32'h4D49_5053;
`ifdef CP0_HWINT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PC = '0;
    logic [31:0] DIn = '0;
    logic [4:0]  Sel = '0;
    logic        Wen = 1'b0;
    logic        EXLSet = 1'b0;
    logic        EXLClr = 1'b0;
    logic [5:0]  HWInt = '0;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    int checks = 0;
    int errors = 0;

    cp0_exc #(.PRID(PRID)) dut (
        .clk(clk), .reset(reset), .PC(PC), .DIn(DIn), .Sel(Sel), .Wen(Wen),
        .EXLSet(EXLSet), .EXLClr(EXLClr), .HWInt(HWInt),
        .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
    );

    always #10 clk = ~clk;

    // Architectural view of the CP0 registers
    logic [5:0]  m_im, m_ip;
    logic        m_ie, m_exl;
    logic [31:0] m_epc;
    logic [5:0]  hist[$];

    task automatic model_reset();
        m_im = '0; m_ip = '0; m_ie = 1'b0; m_exl = 1'b0; m_epc = '0;
        hist.delete();
        for (int i = 0; i < LAT - 1; i++) hist.push_back(6'h00);
    endtask

    // Applies one clock edge worth of register semantics using the current inputs
    task automatic model_edge();
        logic n_exl;
        if (reset) begin
            model_reset();
        end else begin
            hist.push_back(HWInt);
            m_ip = hist.pop_front();
            n_exl = m_exl;
            if (Wen && Sel == 5'd12) begin
                m_im  = DIn[15:10];
                m_ie  = DIn[0];
                n_exl = DIn[1];
            end
            if (EXLClr) n_exl = 1'b0;
            if (EXLSet) n_exl = 1'b1;
            m_exl = n_exl;
            if (EXLSet) m_epc = PC & 32'hFFFF_FFFC;
            else if (Wen && Sel == 5'd14) m_epc = DIn & 32'hFFFF_FFFC;
        end
    endtask

    function automatic logic [31:0] exp_dout(input logic [4:0] s);
        case (s)
            5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
            5'd13:   return {16'h0, m_ip, 10'h0};
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic exp_intreq();
        return (|(m_ip & m_im)) & m_ie & ~m_exl;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [4:0] saved;
        logic [4:0] sels [6] = '{5'd0, 5'd7, 5'd12, 5'd13, 5'd14, 5'd15};
        saved = Sel;
        chk({tag, ".intreq"}, 32'(IntReq), 32'(exp_intreq()));
        chk({tag, ".epc"}, EPC, m_epc);
        foreach (sels[i]) begin
            Sel = sels[i];
            #1;
            chk($sformatf("%s.dout%0d", tag, sels[i]), DOut, exp_dout(sels[i]));
        end
        Sel = saved;
        #1;
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic read_sel(input string tag, input logic [4:0] s, input logic [31:0] exp);
        logic [4:0] saved;
        saved = Sel;
        Sel = s;
        #1;
        chk(tag, DOut, exp);
        Sel = saved;
    endtask

    initial begin
        model_reset();
        HWInt = 6'h3F;
        #2 reset = 1'b1;
        #1;
        chk("rst_intreq", 32'(IntReq), 32'h0);
        chk("rst_epc", EPC, 32'h0);
        read_sel("rst_prid", 5'd15, PRID);
        read_sel("rst_cause", 5'd13, 32'h0);
        tick("rst_hold");
        reset = 1'b0;
        for (int i = 0; i < LAT; i++) tick("ip_latency");

        // Masking: only IM[10] enabled, line 1 asserted
        HWInt = 6'b000010;
        Wen = 1'b1; Sel = 5'd12; DIn = 32'h0000_0401;
        tick("mtc0_sr");
        Wen = 1'b0;
        for (int i = 0; i < LAT + 1; i++) tick("masked");
        chk("masked_intreq", 32'(IntReq), 32'h0);
        HWInt = 6'b000001;
        for (int i = 0; i < LAT; i++) tick("unmask");
        chk("req_raised", 32'(IntReq), 32'h1);
        read_sel("cause_ip0", 5'd13, 32'h0000_0400);

        // Accept and return
        PC = 32'h0000_3010; EXLSet = 1'b1;
        tick("accept");
        EXLSet = 1'b0;
        chk("accept_epc", EPC, 32'h0000_3010);
        read_sel("accept_sr", 5'd12, 32'h0000_0403);
        chk("accept_intreq", 32'(IntReq), 32'h0);
        EXLClr = 1'b1;
        tick("eret");
        EXLClr = 1'b0;
        chk("eret_intreq", 32'(IntReq), 32'h1);

        // Conflicts
        PC = 32'h0000_5020; EXLSet = 1'b1; EXLClr = 1'b1;
        tick("set_clr");
        EXLClr = 1'b0;
        read_sel("set_clr_sr", 5'd12, 32'h0000_0403);
        PC = 32'h0000_6040; Wen = 1'b1; Sel = 5'd14; DIn = 32'h1234_5677;
        tick("set_wepc");
        EXLSet = 1'b0; Wen = 1'b0;
        chk("set_wepc_epc", EPC, 32'h0000_6040);
        Wen = 1'b1; Sel = 5'd12; DIn = 32'h0000_0401; EXLSet = 1'b1;
        tick("set_wsr");
        EXLSet = 1'b0; EXLClr = 1'b1; DIn = 32'h0000_0C03;
        tick("clr_wsr");
        EXLClr = 1'b0; Wen = 1'b0;
        read_sel("clr_wsr_sr", 5'd12, 32'h0000_0C01);

        // EPC alignment and ignored writes
        Wen = 1'b1; Sel = 5'd14; DIn = 32'h0000_3007;
        tick("wepc");
        chk("wepc_align", EPC, 32'h0000_3004);
        Sel = 5'd13; DIn = 32'hFFFF_FFFF;
        tick("wcause");
        Sel = 5'd7;
        tick("wsel7");
        Sel = 5'd15;
        tick("wprid");
        Wen = 1'b0;

        // Mid-cycle reset drops a pending request
        HWInt = 6'h3F;
        for (int i = 0; i < LAT; i++) tick("pre_rst");
        chk("pre_rst_req", 32'(IntReq), 32'h1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_intreq", 32'(IntReq), 32'h0);
        chk("mid_rst_epc", EPC, 32'h0);
        Wen = 1'b1; EXLSet = 1'b1; EXLClr = 1'b1; Sel = 5'd12; DIn = 32'hFFFF_FFFF;
        tick("rst_busy");
        reset = 1'b0; Wen = 1'b0; EXLSet = 1'b0; EXLClr = 1'b0;
        tick("rst_release");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom_range(0, 60) == 0);
            HWInt  = 6'($urandom);
            PC     = $urandom;
            DIn    = $urandom;
            Sel    = 5'($urandom_range(10, 16));
            Wen    = ($urandom_range(0, 2) == 0);
            EXLSet = IntReq ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
            EXLClr = ($urandom_range(0, 5) == 0);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
